clarvi_slice_alu: RTL and testbench
===================================

# clarvi_slice_alu

Multi-cycle integer ALU that executes XLEN-bit RV64-style operations on a SLICE_W-bit datapath, one slice per cycle, carrying inter-slice state (carry, compare flags) in registers. It generalises the two-part 64-on-32 execution scheme to any slice count and adds a valid/ready handshake, so the execute stage can trade area for latency per build. It sits between operand fetch and writeback; LUI/AUIPC/JAL link values stay in the execute stage.

## Interface
- XLEN, 64, operand/result width; must equal NSLICES*SLICE_W.
- SLICE_W, 16, datapath width per cycle; power of two, 8..XLEN, and ≤32 when word ops are used.
- NSLICES, XLEN/SLICE_W (derived localparam), slices per operation.
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  block idle and able to accept.
- op  in  alu_op_t  ADD, SUB, SLT, SLTU, XOR, OR, AND, SL, SRL, SRA.
- is_word  in  1  32-bit (W-suffix) variant.
- rs1  in  XLEN  first operand.
- rs2  in  XLEN  second operand, or immediate already muxed by decode.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  operation result.

## Operation
- FSM: IDLE → RUN on in_valid&&in_ready (latch op, is_word, rs1, rs2; slice counter 0). RUN → DONE after slice NSLICES-1. DONE → IDLE on out_ready.
- in_ready = (state==IDLE). out_valid = (state==DONE). result is registered, held stable through DONE.
- Word pre-processing at accept: shift amount masked to 5 bits; SRAW operand = sign-extend(rs1[31:0]), SRLW operand = zero-extend(rs1[31:0]). Non-word shifts mask to log2(XLEN) bits. Word result = sign-extend(r[31:0]) applied on DONE entry.
- Low-to-high order (slice j = counter): ADD/SUB ripple via 1-bit carry register, init 0 for ADD, 1 for SUB with rs2 inverted; XOR/OR/AND slice-wise; SL with k=amt/SLICE_W, b=amt%SLICE_W: r[j] = (a[j-k]<<b) | (a[j-k-1]>>(SLICE_W-b)), out-of-range slices 0, spill term 0 when b==0.
- High-to-low order (slice j = NSLICES-1-counter): SRL/SRA r[j] = (a[j+k]>>b) | (a[j+k+1]<<(SLICE_W-b)), out-of-range slices = fill (0 for SRL, all-ones if a[XLEN-1] for SRA); SRA top slice arithmetic. SLT/SLTU keep flags {decided, lt}: first unequal slice sets decided and lt (signed compare on top slice for SLT only, unsigned elsewhere); result = {0…, lt}.
- Undefined op: completes normally with result 0.

## Timing
- Reset: state IDLE, in_ready 1, out_valid 0, result 0, carry/flags 0.
- out_valid rises exactly NSLICES cycles after the accepting edge; minimum issue interval NSLICES+2 cycles (accept, NSLICES RUN, DONE handshake).
- in_valid while busy is ignored; operands need only be valid on the accepting edge.
- out_ready low in DONE: hold result and out_valid indefinitely.
- Reset low in any state (including mid-RUN or DONE): next cycle IDLE, out_valid 0, partial result discarded.
- NSLICES=1: single RUN cycle; carry/flag state unused but behaviour identical.

## Structure
- alu_op_t and the op encodings stay in riscv.svh; add slice_state_t (carry, decided, lt) there.
- Sub-module clarvi_alu_slice: combinational SLICE_W-bit slice datapath (inputs: op, operand slices, carry/flags in; outputs: slice result, carry/flags out). Top holds FSM, counter, operand/result registers and slice muxes.

## Test plan
(XLEN=64, SLICE_W=16 unless stated.)
- ADD 0x0000_0000_FFFF_FFFF + 1 → 0x0000_0001_0000_0000, out_valid exactly 4 cycles after accept; SUB 0−1 → 0xFFFF_FFFF_FFFF_FFFF.
- ADDW 0x7FFF_FFFF+1 → 0xFFFF_FFFF_8000_0000; SLLW 1<<31 → 0xFFFF_FFFF_8000_0000; SRAW 0x8000_0000>>>4 → 0xFFFF_FFFF_F800_0000.
- SLT −1 vs 1 → 1; SLTU same → 0; SLT equal operands → 0; SLT 0x1_0000_0000 vs 0xFFFF_FFFF → 0.
- SL 1<<63 → 0x8000_0000_0000_0000; SRA 0x8000_0000_0000_0000>>>36 → 0xFFFF_FFFF_F800_0000; SRL by 0 → rs1 unchanged; SRL amount 67 → treated as 3.
- out_ready low 3 cycles in DONE → result stable, in_ready 0, second in_valid not accepted until IDLE.
- Reset asserted in second RUN cycle → next cycle out_valid 0, in_ready 1; following ADD 2+3 → 5 with normal latency; repeat ADD with SLICE_W=32 and SLICE_W=64 builds (latency 2 and 1).

Source files
------------

// File: rtl/clarvi_slice_alu_pkg.sv
// rtl/clarvi_slice_alu_pkg.sv - shared types for the sliced multi-cycle ALU
package clarvi_slice_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SL   = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;

    typedef struct packed {
        logic carry;
        logic decided;
        logic lt;
    } slice_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    // Right shifts and compares must see the most significant slice first.
    function automatic logic is_high_first(alu_op_t op);
        return (op == ALU_SLT) || (op == ALU_SLTU) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/clarvi_slice_alu_if.sv
// rtl/clarvi_slice_alu_if.sv - issue/result handshake bundle of the sliced ALU
interface clarvi_slice_alu_if
    import clarvi_slice_alu_pkg::*;
#(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    alu_op_t         op;
    logic            is_word;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, is_word, rs1, rs2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, is_word, rs1, rs2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/clarvi_alu_slice.sv
// rtl/clarvi_alu_slice.sv - combinational one-slice datapath with carry/compare state
module clarvi_alu_slice
    import clarvi_slice_alu_pkg::*;
#(
    parameter int SLICE_W = 16,
    localparam int BW     = (SLICE_W > 1) ? $clog2(SLICE_W) : 1
) (
    input  alu_op_t            op,
    input  logic               is_top,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] a_near,
    input  logic [SLICE_W-1:0] b,
    input  logic [BW-1:0]      bit_amt,
    input  slice_state_t       st_in,
    output logic [SLICE_W-1:0] r,
    output slice_state_t       st_out
);
    localparam logic [BW:0] SW_L = SLICE_W[BW:0];

    logic [SLICE_W:0]   sum;
    logic [BW:0]        inv_amt;
    logic [SLICE_W-1:0] spill;

    always_comb begin
        r       = '0;
        st_out  = st_in;
        sum     = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, st_in.carry};
        inv_amt = SW_L - {1'b0, bit_amt};
        spill   = '0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                r            = sum[SLICE_W-1:0];
                st_out.carry = sum[SLICE_W];
            end
            ALU_XOR: r = a ^ b;
            ALU_OR:  r = a | b;
            ALU_AND: r = a & b;
            ALU_SL: begin
                if (bit_amt != '0) spill = a_near >> inv_amt;
                r = (a << bit_amt) | spill;
            end
            ALU_SRL, ALU_SRA: begin
                // Sign fill arrives through a_near, so SRA needs no special top-slice path.
                if (bit_amt != '0) spill = a_near << inv_amt;
                r = (a >> bit_amt) | spill;
            end
            ALU_SLT, ALU_SLTU: begin
                if (!st_in.decided && (a != b)) begin
                    st_out.decided = 1'b1;
                    st_out.lt      = (op == ALU_SLT && is_top) ? ($signed(a) < $signed(b)) : (a < b);
                end
            end
            default: r = '0;
        endcase
    end
endmodule

// File: rtl/clarvi_slice_alu.sv
// rtl/clarvi_slice_alu.sv - XLEN-bit ALU executed one SLICE_W-bit slice per cycle
module clarvi_slice_alu
    import clarvi_slice_alu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int SLICE_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    clarvi_slice_alu_if.slave bus
);
    localparam int NSLICES = XLEN / SLICE_W;
    localparam int CW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam int AW      = $clog2(XLEN);
    localparam int BW      = (SLICE_W > 1) ? $clog2(SLICE_W) : 1;

    fsm_state_t         state, state_next;
    logic [CW-1:0]      cnt;
    alu_op_t            op_q;
    logic               word_q;
    logic [XLEN-1:0]    a_q, b_q, res_q, res_next, res_final;
    logic [AW-1:0]      amt_q;
    slice_state_t       st_q, st_out;
    logic               last;
    int                 sl_idx, sh_k;
    logic [SLICE_W-1:0] fill, a_main, a_near, b_slice, r_slice;
    logic [XLEN-1:0]    a_in, b_in;
    logic [AW-1:0]      amt_in;

    function automatic logic [SLICE_W-1:0] slice_of(logic [XLEN-1:0] v, int idx,
                                                    logic [SLICE_W-1:0] fill_v);
        if (idx < 0 || idx >= NSLICES) return fill_v;
        return v[idx*SLICE_W +: SLICE_W];
    endfunction

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = res_q;
    assign last          = (cnt == CW'(NSLICES - 1));

    // Operand conditioning happens once, at accept, so RUN never looks at is_word.
    always_comb begin
        a_in   = bus.rs1;
        b_in   = (bus.op == ALU_SUB) ? ~bus.rs2 : bus.rs2;
        amt_in = bus.is_word ? AW'(bus.rs2[4:0]) : bus.rs2[AW-1:0];
        if (bus.is_word && bus.op == ALU_SRA) a_in = {{(XLEN-32){bus.rs1[31]}}, bus.rs1[31:0]};
        if (bus.is_word && bus.op == ALU_SRL) a_in = {{(XLEN-32){1'b0}}, bus.rs1[31:0]};
    end

    always_comb begin
        sl_idx  = is_high_first(op_q) ? (NSLICES - 1 - int'(cnt)) : int'(cnt);
        sh_k    = int'(amt_q >> BW);
        fill    = (op_q == ALU_SRA && a_q[XLEN-1]) ? '1 : '0;
        b_slice = slice_of(b_q, sl_idx, '0);
        a_main  = slice_of(a_q, sl_idx, '0);
        a_near  = '0;
        case (op_q)
            ALU_SL: begin
                a_main = slice_of(a_q, sl_idx - sh_k, '0);
                a_near = slice_of(a_q, sl_idx - sh_k - 1, '0);
            end
            ALU_SRL, ALU_SRA: begin
                a_main = slice_of(a_q, sl_idx + sh_k, fill);
                a_near = slice_of(a_q, sl_idx + sh_k + 1, fill);
            end
            default: ;
        endcase
    end

    clarvi_alu_slice #(.SLICE_W(SLICE_W)) u_slice (
        .op      (op_q),
        .is_top  (sl_idx == NSLICES - 1),
        .a       (a_main),
        .a_near  (a_near),
        .b       (b_slice),
        .bit_amt (amt_q[BW-1:0]),
        .st_in   (st_q),
        .r       (r_slice),
        .st_out  (st_out)
    );

    always_comb begin
        res_next = res_q;
        res_next[sl_idx*SLICE_W +: SLICE_W] = r_slice;
        res_final = res_next;
        if (op_q == ALU_SLT || op_q == ALU_SLTU) res_final = {{(XLEN-1){1'b0}}, st_out.lt};
        else if (word_q) res_final = {{(XLEN-32){res_next[31]}}, res_next[31:0]};
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.in_valid) state_next = ST_RUN;
            ST_RUN:  if (last) state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= ALU_ADD;
            word_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            amt_q  <= '0;
            st_q   <= '0;
            res_q  <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && bus.in_valid) begin
                cnt    <= '0;
                op_q   <= bus.op;
                word_q <= bus.is_word;
                a_q    <= a_in;
                b_q    <= b_in;
                amt_q  <= amt_in;
                st_q   <= '{carry: (bus.op == ALU_SUB), decided: 1'b0, lt: 1'b0};
            end else if (state == ST_RUN) begin
                cnt   <= cnt + 1'b1;
                st_q  <= st_out;
                res_q <= last ? res_final : res_next;
            end
        end
    end
endmodule

// File: tb/tb_clarvi_slice_alu.sv
// tb/tb_clarvi_slice_alu.sv - self-checking bench over 16/32/64-bit slice builds
module tb_clarvi_slice_alu;
    import clarvi_slice_alu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    clarvi_slice_alu_if #(.XLEN(64)) if16 ();
    clarvi_slice_alu_if #(.XLEN(64)) if32 ();
    clarvi_slice_alu_if #(.XLEN(64)) if64 ();

    clarvi_slice_alu #(.XLEN(64), .SLICE_W(16)) dut16 (.clock(clock), .reset(reset), .bus(if16));
    clarvi_slice_alu #(.XLEN(64), .SLICE_W(32)) dut32 (.clock(clock), .reset(reset), .bus(if32));
    clarvi_slice_alu #(.XLEN(64), .SLICE_W(64)) dut64 (.clock(clock), .reset(reset), .bus(if64));

    typedef struct packed {
        alu_op_t     op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input alu_op_t op, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        if16.in_valid = v; if16.op = op; if16.is_word = w; if16.rs1 = a; if16.rs2 = b;
        if32.in_valid = v; if32.op = op; if32.is_word = w; if32.rs1 = a; if32.rs2 = b;
        if64.in_valid = v; if64.op = op; if64.is_word = w; if64.rs1 = a; if64.rs2 = b;
    endtask

    task automatic set_out_ready(input logic v);
        if16.out_ready = v; if32.out_ready = v; if64.out_ready = v;
    endtask

    // Reference straight from the RV64 operation definitions.
    function automatic logic [63:0] ref_alu(alu_op_t op, logic w, logic [63:0] a, logic [63:0] b);
        logic [63:0] r;
        int sh;
        sh = w ? int'(b[4:0]) : int'(b[5:0]);
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLT:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            ALU_SLTU: r = (a < b) ? 64'd1 : 64'd0;
            ALU_XOR:  r = a ^ b;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_SL:   r = a << sh;
            ALU_SRL:  r = w ? ({32'd0, a[31:0]} >> sh) : (a >> sh);
            ALU_SRA:  r = w ? 64'($signed({{32{a[31]}}, a[31:0]}) >>> sh) : 64'($signed(a) >>> sh);
            default:  r = 64'd0;
        endcase
        if (w && op != ALU_SLT && op != ALU_SLTU) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    task automatic run_op(input alu_op_t op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input string name);
        logic        seen [3];
        int          lat  [3];
        logic [63:0] got  [3];
        for (int i = 0; i < 3; i++) begin seen[i] = 1'b0; lat[i] = 0; got[i] = '0; end
        @(negedge clock);
        check({name, "/in_ready"}, {61'd0, if16.in_ready, if32.in_ready, if64.in_ready}, 64'd7);
        drive(1'b1, op, w, a, b);
        @(posedge clock); #1;
        drive(1'b0, op, w, {$urandom, $urandom}, {$urandom, $urandom});
        for (int c = 1; c <= 20 && !(seen[0] && seen[1] && seen[2]); c++) begin
            @(posedge clock); #1;
            if (!seen[0] && if16.out_valid) begin seen[0] = 1'b1; lat[0] = c; got[0] = if16.result; end
            if (!seen[1] && if32.out_valid) begin seen[1] = 1'b1; lat[1] = c; got[1] = if32.result; end
            if (!seen[2] && if64.out_valid) begin seen[2] = 1'b1; lat[2] = c; got[2] = if64.result; end
        end
        check({name, "/lat16"}, 64'(lat[0]), 64'd4);
        check({name, "/lat32"}, 64'(lat[1]), 64'd2);
        check({name, "/lat64"}, 64'(lat[2]), 64'd1);
        check({name, "/res16"}, got[0], exp);
        check({name, "/res32"}, got[1], exp);
        check({name, "/res64"}, got[2], exp);
        @(posedge clock); #1;
    endtask

    task automatic check_idle(input string name, input logic [63:0] exp_res);
        check({name, "/out_valid"}, {61'd0, if16.out_valid, if32.out_valid, if64.out_valid}, 64'd0);
        check({name, "/in_ready"},  {61'd0, if16.in_ready,  if32.in_ready,  if64.in_ready},  64'd7);
        check({name, "/res16"}, if16.result, exp_res);
        check({name, "/res64"}, if64.result, exp_res);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_op_t     rop;
        logic        rw;
        logic [63:0] ra, rb;

        drive(1'b0, ALU_ADD, 1'b0, '0, '0);
        set_out_ready(1'b1);
        repeat (3) @(posedge clock);
        #1;
        check_idle("reset", 64'd0);
        reset = 1'b1;

        vecs.push_back('{ALU_ADD,  1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'h0000_0001_0000_0000});
        vecs.push_back('{ALU_SUB,  1'b0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{ALU_ADD,  1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{ALU_SL,   1'b1, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{ALU_SRA,  1'b1, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000});
        vecs.push_back('{ALU_SLT,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1});
        vecs.push_back('{ALU_SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0});
        vecs.push_back('{ALU_SLT,  1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0});
        vecs.push_back('{ALU_SLT,  1'b0, 64'h1_0000_0000, 64'hFFFF_FFFF, 64'd0});
        vecs.push_back('{ALU_SL,   1'b0, 64'd1, 64'd63, 64'h8000_0000_0000_0000});
        vecs.push_back('{ALU_SRA,  1'b0, 64'h8000_0000_0000_0000, 64'd36, 64'hFFFF_FFFF_F800_0000});
        vecs.push_back('{ALU_SRL,  1'b0, 64'hDEAD_BEEF_0123_4567, 64'd0, 64'hDEAD_BEEF_0123_4567});
        vecs.push_back('{ALU_SRL,  1'b0, 64'hF000_0000_0000_0080, 64'd67, 64'h1E00_0000_0000_0010});
        vecs.push_back('{ALU_XOR,  1'b0, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF00F_F00F_F00F_F00F});
        vecs.push_back('{ALU_AND,  1'b0, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F00_0F00_0F00_0F00});
        vecs.push_back('{ALU_OR,   1'b0, 64'hFF00_0000_0000_0000, 64'h0000_0000_0000_00FF, 64'hFF00_0000_0000_00FF});
        vecs.push_back('{alu_op_t'(4'hF), 1'b0, 64'h1234, 64'h5678, 64'd0});

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rop = ($urandom_range(0, 15) == 0) ? alu_op_t'(4'hE) : alu_op_t'($urandom_range(0, 9));
            rw  = ($urandom_range(0, 3) == 0);
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb = ra;
            if ($urandom_range(0, 3) == 0) rb = {ra[63:32], $urandom};
            run_op(rop, rw, ra, rb, ref_alu(rop, rw, ra, rb), $sformatf("rnd%0d", i));
        end

        // Consumer stalls in DONE while a second request is waiting.
        set_out_ready(1'b0);
        @(negedge clock);
        drive(1'b1, ALU_ADD, 1'b0, 64'd100, 64'd23);
        @(posedge clock); #1;
        drive(1'b0, ALU_ADD, 1'b0, '0, '0);
        repeat (4) @(posedge clock);
        #1;
        drive(1'b1, ALU_SUB, 1'b0, 64'd50, 64'd50);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall%0d/out_valid", i),
                  {61'd0, if16.out_valid, if32.out_valid, if64.out_valid}, 64'd7);
            check($sformatf("stall%0d/in_ready", i),
                  {61'd0, if16.in_ready, if32.in_ready, if64.in_ready}, 64'd0);
            check($sformatf("stall%0d/res16", i), if16.result, 64'd123);
            check($sformatf("stall%0d/res32", i), if32.result, 64'd123);
            @(posedge clock); #1;
        end
        drive(1'b0, ALU_ADD, 1'b0, '0, '0);
        set_out_ready(1'b1);
        @(posedge clock); #1;
        check_idle("release", 64'd123);
        repeat (5) @(posedge clock);
        #1;
        check_idle("no_phantom", 64'd123);

        // Reset during the second RUN cycle of the 16-bit build.
        @(negedge clock);
        drive(1'b1, ALU_ADD, 1'b0, 64'd10, 64'd20);
        @(posedge clock); #1;
        drive(1'b0, ALU_ADD, 1'b0, '0, '0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        check_idle("midrun_reset", 64'd0);
        run_op(ALU_ADD, 1'b0, 64'd2, 64'd3, 64'd5, "post_reset_add");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
